// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: run-state encoding, result window size and program address tables
package cpu_run_ctrl_pkg;
  localparam int RES_BYTES = 16;
  localparam int LW = $clog2(RES_BYTES + 1);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_CLEAR, S_RUN, S_CAPTURE, S_DRAIN, S_DONE} run_state_t;
  localparam logic [31:0] PROG_START [4] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300};
  localparam logic [31:0] PROG_END [4] = '{32'h0000_00fc, 32'h0000_01fc, 32'h0000_02fc, 32'h0000_03fc};
  function automatic logic [31:0] prog_start(input logic [31:0] idx);
    return idx < 32'd4 ? PROG_START[idx[1:0]] : '0;
  endfunction
  function automatic logic [31:0] prog_end(input logic [31:0] idx);
    return idx < 32'd4 ? PROG_END[idx[1:0]] : '0;
  endfunction
endpackage

// File: rtl/res_byte_shifter.sv
// res_byte_shifter: holds the captured result window and emits it byte 0 first over valid/ready
module res_byte_shifter
  import cpu_run_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [8*RES_BYTES-1:0] res,
  input  logic [LW-1:0]          len,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   out_last
);
  logic [8*RES_BYTES-1:0] res_q;
  logic [LW-1:0] rem;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      rem <= '0;
    end else if (load) begin
      res_q <= res;
      rem <= len;
    end else if (out_valid && out_ready) begin
      res_q <= {8'h00, res_q[8*RES_BYTES-1:8]};
      rem <= rem - 1'b1;
    end
  end
  assign out_valid = rem != '0;
  assign out_data = res_q[7:0];
  assign out_last = rem == LW'(1);
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: launches a CPU program run, waits for its result and streams the bytes out.
// Optional RUN_WATCHDOG_EN adds a CLEAR/RUN timeout that aborts to DONE with err_timeout.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int NUM_PROGS = 4,
  parameter int ENCODE_HOLD = 4
`ifdef RUN_WATCHDOG_EN
  , parameter int TIMEOUT_CYC = 2**24
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(NUM_PROGS)-1:0] req_prog,
  output logic                         cpu_encode,
  output logic [31:0]                  cpu_prognum,
  output logic [31:0]                  cpu_initialeip,
  output logic [31:0]                  cpu_endeip,
  input  logic                         cpu_finalflag,
  input  logic [127:0]                 cpu_finalres,
  input  logic [31:0]                  cpu_finallength,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic                         out_last,
  output logic                         done,
  output logic                         busy,
  output logic                         err_len,
  output logic                         err_timeout
);
  run_state_t state, nxt;
  logic [$clog2(ENCODE_HOLD)-1:0] enc_cnt;
  logic accept, over, wd_hit, hs_last;
  logic [LW-1:0] cap_len;
  assign accept = req_valid & req_ready;
  assign over = cpu_finallength > 32'(RES_BYTES);
  assign cap_len = over ? LW'(RES_BYTES) : cpu_finallength[LW-1:0];
  assign hs_last = out_valid & out_ready & out_last;
  assign req_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign cpu_encode = state == S_LAUNCH;
`ifdef RUN_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic waiting;
  assign waiting = state == S_CLEAR || state == S_RUN;
  assign wd_hit = waiting && wd_cnt == 32'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= accept ? '0 : waiting ? wd_cnt + 1'b1 : wd_cnt;
      err_timeout <= accept ? 1'b0 : (err_timeout | wd_hit);
    end
  end
`else
  assign wd_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      enc_cnt <= '0;
      cpu_prognum <= '0;
      cpu_initialeip <= '0;
      cpu_endeip <= '0;
      err_len <= 1'b0;
    end else begin
      state <= nxt;
      enc_cnt <= state == S_LAUNCH ? enc_cnt + 1'b1 : '0;
      if (accept) begin
        cpu_prognum <= 32'(req_prog);
        cpu_initialeip <= prog_start(32'(req_prog));
        cpu_endeip <= prog_end(32'(req_prog));
      end
      err_len <= accept ? 1'b0 : (err_len | (state == S_CAPTURE && over));
    end
  end
  // A stale finalflag from the previous run must fall before a new rise is trusted
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = accept ? S_LAUNCH : S_IDLE;
      S_LAUNCH:  nxt = enc_cnt == ($bits(enc_cnt))'(ENCODE_HOLD - 1) ? S_CLEAR : S_LAUNCH;
      S_CLEAR:   nxt = wd_hit ? S_DONE : !cpu_finalflag ? S_RUN : S_CLEAR;
      S_RUN:     nxt = cpu_finalflag ? S_CAPTURE : wd_hit ? S_DONE : S_RUN;
      S_CAPTURE: nxt = cap_len != '0 ? S_DRAIN : S_DONE;
      S_DRAIN:   nxt = hs_last ? S_DONE : S_DRAIN;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end
  res_byte_shifter u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state == S_CAPTURE),
    .res       (cpu_finalres),
    .len       (cap_len),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized runs against a CPU model and a byte-queue reference of the result stream
module tb_cpu_run_ctrl;
  logic clk = 0, rst_n = 0, req_valid = 0, out_ready = 0;
  logic [1:0] req_prog = 0;
  logic cpu_finalflag = 0;
  logic [127:0] cpu_finalres = '0;
  logic [31:0] cpu_finallength = '0;
  logic req_ready, cpu_encode, out_valid, out_last, done, busy, err_len, err_timeout;
  logic [31:0] cpu_prognum, cpu_initialeip, cpu_endeip;
  logic [7:0] out_data;
  int compares = 0, mismatches = 0;
  logic [31:0] start_tab [4] = '{32'h000, 32'h100, 32'h200, 32'h300};
  logic [31:0] end_tab [4] = '{32'h0fc, 32'h1fc, 32'h2fc, 32'h3fc};

  always #5 clk = ~clk;

`ifdef RUN_WATCHDOG_EN
  cpu_run_ctrl #(.TIMEOUT_CYC(100)) dut (
`else
  cpu_run_ctrl dut (
`endif
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_prog(req_prog),
    .cpu_encode(cpu_encode), .cpu_prognum(cpu_prognum), .cpu_initialeip(cpu_initialeip),
    .cpu_endeip(cpu_endeip), .cpu_finalflag(cpu_finalflag), .cpu_finalres(cpu_finalres),
    .cpu_finallength(cpu_finallength), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done), .busy(busy), .err_len(err_len),
    .err_timeout(err_timeout));

  // CPU model: on an encode rise, drop finalflag after cpu_stale cycles, raise it with the new result after cpu_delay
  logic [127:0] cpu_res_n = '0;
  logic [31:0] cpu_len_n = '0;
  int cpu_stale = 0, cpu_delay = 10, cnt = 0;
  bit cpu_never = 0, act = 0;
  logic enc_d = 0;
  always @(posedge clk) begin
    enc_d <= cpu_encode;
    if (cpu_encode && !enc_d) begin
      cnt <= 0;
      act <= 1;
    end else if (act) begin
      cnt <= cnt + 1;
      if (cnt == cpu_stale) cpu_finalflag <= 0;
      if (cnt == cpu_delay && !cpu_never) begin
        cpu_finalflag <= 1;
        cpu_finalres <= cpu_res_n;
        cpu_finallength <= cpu_len_n;
        act <= 0;
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    compares++;
    if (!req_ready) begin
      mismatches++;
      $display("FAIL wait_ready: req_ready=%0b want 1", req_ready);
    end
  endtask

  task automatic run_one(input int prog, input logic [31:0] flen, input logic [127:0] res,
                         input int rdy_pct, input int stale, input bit junk);
    logic [7:0] exp_q[$];
    logic [7:0] held;
    bit stalled, got_done;
    int n, last_hs;
    n = (flen > 16) ? 16 : int'(flen);
    for (int k = 0; k < n; k++) exp_q.push_back(res[8*k +: 8]);
    cpu_res_n = res;
    cpu_len_n = flen;
    cpu_stale = stale;
    cpu_delay = stale + 10;
    wait_ready();
    req_valid = 1;
    req_prog = 2'(prog);
    @(negedge clk);
    req_valid = 0;
    compares++;
    if (cpu_prognum !== 32'(prog)) begin mismatches++; $display("FAIL prognum: got %0h want %0h", cpu_prognum, prog); end
    compares++;
    if (cpu_initialeip !== start_tab[prog]) begin mismatches++; $display("FAIL initialeip: got %0h want %0h", cpu_initialeip, start_tab[prog]); end
    compares++;
    if (cpu_endeip !== end_tab[prog]) begin mismatches++; $display("FAIL endeip: got %0h want %0h", cpu_endeip, end_tab[prog]); end
    compares++;
    if ({cpu_encode, busy, req_ready, err_len, err_timeout} !== 5'b11000) begin
      mismatches++;
      $display("FAIL after_accept: enc/busy/rdy/elen/eto=%b want 11000", {cpu_encode, busy, req_ready, err_len, err_timeout});
    end
    stalled = 0;
    got_done = 0;
    last_hs = -1;
    held = '0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      out_ready = $urandom_range(99) < rdy_pct;
      if (junk) begin
        req_valid = 1'($urandom_range(1));
        req_prog = 2'($urandom);
      end
      #1;
      if (stalled) begin
        compares++;
        if (!out_valid || out_data !== held) begin
          mismatches++;
          $display("FAIL stall_hold: valid=%0b data=%0h want 1 %0h", out_valid, out_data, held);
        end
      end
      stalled = 0;
      if (done) begin
        got_done = 1;
        compares++;
        if (exp_q.size() != 0) begin mismatches++; $display("FAIL bytes_left: got %0d want 0", exp_q.size()); end
        compares++;
        if (err_len !== (flen > 16)) begin mismatches++; $display("FAIL err_len: got %0b want %0b", err_len, flen > 16); end
        if (n > 0) begin
          compares++;
          if (c != last_hs + 1) begin mismatches++; $display("FAIL done_timing: got cycle %0d want %0d", c, last_hs + 1); end
        end
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          compares++;
          mismatches++;
          $display("FAIL extra_byte: got %0h want none", out_data);
        end else if (out_ready) begin
          compares++;
          if (out_data !== exp_q[0]) begin mismatches++; $display("FAIL data: got %0h want %0h", out_data, exp_q[0]); end
          compares++;
          if (out_last !== (exp_q.size() == 1)) begin mismatches++; $display("FAIL last: got %0b want %0b", out_last, exp_q.size() == 1); end
          void'(exp_q.pop_front());
          last_hs = c;
        end else begin
          stalled = 1;
          held = out_data;
        end
      end
      @(negedge clk);
    end
    req_valid = 0;
    out_ready = 0;
    if (!got_done) begin
      compares++;
      mismatches++;
      $display("FAIL run_timeout: done=0 want 1");
    end
    #1;
    compares++;
    if ({done, busy, req_ready} !== 3'b001) begin mismatches++; $display("FAIL back_idle: done/busy/rdy=%b want 001", {done, busy, req_ready}); end
    compares++;
    if (cpu_prognum !== 32'(prog)) begin mismatches++; $display("FAIL prognum_held: got %0h want %0h", cpu_prognum, prog); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    compares++;
    if ({req_ready, busy, done, cpu_encode, out_valid, out_last, err_len, err_timeout, out_data} !== 16'h8000) begin
      mismatches++;
      $display("FAIL reset_outputs: got %h want 8000", {req_ready, busy, done, cpu_encode, out_valid, out_last, err_len, err_timeout, out_data});
    end
    compares++;
    if ({cpu_prognum, cpu_initialeip, cpu_endeip} !== 96'h0) begin
      mismatches++;
      $display("FAIL reset_regs: got %h want 0", {cpu_prognum, cpu_initialeip, cpu_endeip});
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    compares++;
    if ({req_ready, busy} !== 2'b10) begin mismatches++; $display("FAIL idle_after_reset: rdy/busy=%b want 10", {req_ready, busy}); end
  endtask

  task automatic test_hello();
    string s = "Hello";
    logic [127:0] r = '0;
    for (int k = 0; k < 5; k++) r[8*k +: 8] = s[k];
    run_one(1, 5, r, 100, 0, 0);
  endtask

  task automatic test_zero_len();
    run_one(2, 0, rnd128(), 100, 0, 0);
  endtask

  task automatic test_overlong();
    run_one(3, 40, rnd128(), 100, 0, 0);
    repeat (3) @(negedge clk);
    compares++;
    if (err_len !== 1'b1) begin mismatches++; $display("FAIL err_len_sticky: got %0b want 1", err_len); end
  endtask

  task automatic test_random_ready();
    for (int i = 0; i < 8; i++)
      run_one(int'($urandom_range(3)), $urandom_range(20), rnd128(), 50, 0, 1);
  endtask

  task automatic test_stale_flag();
    compares++;
    if (cpu_finalflag !== 1'b1) begin mismatches++; $display("FAIL stale_setup: flag=%0b want 1", cpu_finalflag); end
    run_one(0, 7, rnd128(), 50, 20, 0);
  endtask

  task automatic test_reset_mid_drain();
    int t = 0;
    cpu_res_n = rnd128();
    cpu_len_n = 16;
    cpu_stale = 0;
    cpu_delay = 10;
    wait_ready();
    req_valid = 1;
    req_prog = 2;
    @(negedge clk);
    req_valid = 0;
    out_ready = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    compares++;
    if (!out_valid) begin mismatches++; $display("FAIL drain_reach: out_valid=%0b want 1", out_valid); end
    rst_n = 0;
    #1;
    compares++;
    if ({req_ready, busy, out_valid, out_last, done, cpu_encode, out_data} !== 14'h2000) begin
      mismatches++;
      $display("FAIL mid_reset: got %h want 2000", {req_ready, busy, out_valid, out_last, done, cpu_encode, out_data});
    end
    compares++;
    if (cpu_prognum !== 32'h0) begin mismatches++; $display("FAIL mid_reset_prognum: got %0h want 0", cpu_prognum); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_hello();
  endtask

`ifdef RUN_WATCHDOG_EN
  task automatic test_watchdog();
    int c = 0;
    bit saw_valid = 0;
    cpu_never = 1;
    cpu_stale = 0;
    wait_ready();
    req_valid = 1;
    req_prog = 1;
    @(negedge clk);
    req_valid = 0;
    out_ready = 1;
    while (!done && c < 400) begin
      @(negedge clk);
      c++;
      if (out_valid) saw_valid = 1;
    end
    compares++;
    if (!done) begin mismatches++; $display("FAIL wd_done: done=%0b want 1", done); end
    compares++;
    if (c < 100 || c > 110) begin mismatches++; $display("FAIL wd_cycles: got %0d want 100..110", c); end
    compares++;
    if (err_timeout !== 1'b1) begin mismatches++; $display("FAIL wd_err: got %0b want 1", err_timeout); end
    compares++;
    if (saw_valid) begin mismatches++; $display("FAIL wd_bytes: out_valid seen want none"); end
    out_ready = 0;
    repeat (2) @(negedge clk);
    compares++;
    if ({err_timeout, req_ready} !== 2'b11) begin mismatches++; $display("FAIL wd_sticky: eto/rdy=%b want 11", {err_timeout, req_ready}); end
    cpu_never = 0;
    test_hello();
    compares++;
    if (err_timeout !== 1'b0) begin mismatches++; $display("FAIL wd_clear: got %0b want 0", err_timeout); end
  endtask
`endif

  initial begin
    test_reset();
    test_hello();
    test_zero_len();
    test_overlong();
    test_random_ready();
    test_stale_flag();
    test_reset_mid_drain();
`ifdef RUN_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end
endmodule
